// File: rtl/df_stage.sv
// Data-fetch stage: latches execute results, runs one data-SRAM access per
// instruction over req/addr_ok/data_ok, and extends load data for writeback.
module df_stage #(
   parameter int unsigned STALL_WD = 6
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [STALL_WD-1:0] stall,
   output logic                stallreq_for_df,

   input  logic [31:0]         ex_pc,
   input  logic [31:0]         ex_result,
   input  logic [7:0]          ex_mem_op,
   input  logic                ex_mem_en,
   input  logic [3:0]          ex_mem_wstrb,
   input  logic [31:0]         ex_mem_wdata,
   input  logic                ex_rf_we,
   input  logic [4:0]          ex_rf_waddr,
   input  logic [65:0]         ex_hilo,

   output logic                data_req,
   output logic                data_wr,
   output logic [3:0]          data_wstrb,
   output logic [31:0]         data_addr,
   output logic [31:0]         data_wdata,
   input  logic                data_addr_ok,
   input  logic                data_data_ok,
   input  logic [31:0]         data_rdata,

   output logic [31:0]         df_pc,
   output logic                df_rf_we,
   output logic [4:0]          df_rf_waddr,
   output logic [31:0]         df_rf_wdata,
   output logic [65:0]         df_hilo,
   output logic [38:0]         df_fwd
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ADDR = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] result;
      logic [4:0]  ld_op;   // {lb,lbu,lh,lhu,lw}
      logic        mem_en;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic        rf_we;
      logic [4:0]  waddr;
      logic [65:0] hilo;
   } stage_t;

   stage_t      stage_q, stage_d;
   logic [1:0]  state_q, state_d;
   logic [31:0] rbuf_q, rbuf_d;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic        is_load;

   logic unused_ok;
   assign unused_ok = &{1'b0, stall[3:0], ex_mem_op[2:0]};

   always_comb begin
      stage_d = stage_q;
      state_d = state_q;
      rbuf_d  = rbuf_q;
      case (state_q)
         S_ADDR: if (data_addr_ok) state_d = S_WAIT;
         S_WAIT: begin
            if (data_data_ok) begin
               rbuf_d  = data_rdata;
               state_d = S_DONE;
            end
         end
         default: ;
      endcase
      // A newly latched instruction (or bubble) overrides the handshake progress.
      if (!stall[4]) begin
         stage_d.pc     = ex_pc;
         stage_d.result = ex_result;
         stage_d.ld_op  = ex_mem_op[7:3];
         stage_d.mem_en = ex_mem_en;
         stage_d.wstrb  = ex_mem_wstrb;
         stage_d.wdata  = ex_mem_wdata;
         stage_d.rf_we  = ex_rf_we;
         stage_d.waddr  = ex_rf_waddr;
         stage_d.hilo   = ex_hilo;
         state_d        = ex_mem_en ? S_ADDR : S_DONE;
      end else if (!stall[5]) begin
         stage_d = '0;
         state_d = S_DONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stage_q <= '0;
         state_q <= S_IDLE;
         rbuf_q  <= '0;
      end else begin
         stage_q <= stage_d;
         state_q <= state_d;
         rbuf_q  <= rbuf_d;
      end
   end

   assign stallreq_for_df = stage_q.mem_en & ((state_q == S_ADDR) | (state_q == S_WAIT));

   assign data_req   = (state_q == S_ADDR);
   assign data_wr    = |stage_q.wstrb;
   assign data_wstrb = stage_q.wstrb;
   assign data_addr  = {stage_q.result[31:2], 2'b00};
   assign data_wdata = stage_q.wdata;

   always_comb begin
      case (stage_q.result[1:0])
         2'd0:    ld_byte = rbuf_q[7:0];
         2'd1:    ld_byte = rbuf_q[15:8];
         2'd2:    ld_byte = rbuf_q[23:16];
         default: ld_byte = rbuf_q[31:24];
      endcase
      ld_half = stage_q.result[1] ? rbuf_q[31:16] : rbuf_q[15:0];
      ld_data = rbuf_q;
      if (stage_q.ld_op[4])      ld_data = {{24{ld_byte[7]}}, ld_byte};
      else if (stage_q.ld_op[3]) ld_data = {24'h0, ld_byte};
      else if (stage_q.ld_op[2]) ld_data = {{16{ld_half[15]}}, ld_half};
      else if (stage_q.ld_op[1]) ld_data = {16'h0, ld_half};
   end

   assign is_load     = |stage_q.ld_op;
   assign df_pc       = stage_q.pc;
   assign df_rf_waddr = stage_q.waddr;
   assign df_rf_wdata = is_load ? ld_data : stage_q.result;
   // Write enables are suppressed while the access is outstanding so bypass never sees a partial result.
   assign df_rf_we    = stage_q.rf_we & ~stallreq_for_df;
   assign df_hilo     = {stage_q.hilo[65] & ~stallreq_for_df, stage_q.hilo[64:33],
                         stage_q.hilo[32] & ~stallreq_for_df, stage_q.hilo[31:0]};
   assign df_fwd      = {is_load, df_rf_we, df_rf_waddr, df_rf_wdata};

endmodule

// File: tb/tb_df_stage.sv
// Scoreboard bench for df_stage: expected write-back values are queued at issue
// and popped when the stage finishes the instruction.
module tb_df_stage;

   localparam logic [7:0] OP_LB  = 8'h80;
   localparam logic [7:0] OP_LBU = 8'h40;
   localparam logic [7:0] OP_LH  = 8'h20;
   localparam logic [7:0] OP_LHU = 8'h10;
   localparam logic [7:0] OP_LW  = 8'h08;
   localparam logic [7:0] OP_SW  = 8'h01;

   logic        clk = 1'b0;
   logic        resetn;
   logic [5:0]  stall, stall_tb;
   logic        stallreq_for_df;
   logic [31:0] ex_pc, ex_result, ex_mem_wdata;
   logic [7:0]  ex_mem_op;
   logic        ex_mem_en, ex_rf_we;
   logic [3:0]  ex_mem_wstrb;
   logic [4:0]  ex_rf_waddr;
   logic [65:0] ex_hilo;
   logic        data_req, data_wr, data_addr_ok, data_data_ok;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [31:0] df_pc, df_rf_wdata;
   logic        df_rf_we;
   logic [4:0]  df_rf_waddr;
   logic [65:0] df_hilo;
   logic [38:0] df_fwd;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   // Pipeline control: honour the stage's own stall request by freezing everything.
   assign stall = stallreq_for_df ? 6'h3F : stall_tb;

   df_stage #(.STALL_WD(6)) dut (
      .clk(clk), .resetn(resetn), .stall(stall), .stallreq_for_df(stallreq_for_df),
      .ex_pc(ex_pc), .ex_result(ex_result), .ex_mem_op(ex_mem_op), .ex_mem_en(ex_mem_en),
      .ex_mem_wstrb(ex_mem_wstrb), .ex_mem_wdata(ex_mem_wdata), .ex_rf_we(ex_rf_we),
      .ex_rf_waddr(ex_rf_waddr), .ex_hilo(ex_hilo),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .df_pc(df_pc), .df_rf_we(df_rf_we), .df_rf_waddr(df_rf_waddr), .df_rf_wdata(df_rf_wdata),
      .df_hilo(df_hilo), .df_fwd(df_fwd)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop();
      ex_pc = '0; ex_result = '0; ex_mem_op = '0; ex_mem_en = 1'b0; ex_mem_wstrb = '0;
      ex_mem_wdata = '0; ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_hilo = '0;
   endtask

   task automatic issue(input logic [31:0] pc, input logic [31:0] result, input logic [7:0] op,
                        input logic en, input logic [3:0] strb, input logic [31:0] wdata,
                        input logic we, input logic [4:0] waddr, input logic [65:0] hilo);
      ex_pc = pc; ex_result = result; ex_mem_op = op; ex_mem_en = en; ex_mem_wstrb = strb;
      ex_mem_wdata = wdata; ex_rf_we = we; ex_rf_waddr = waddr; ex_hilo = hilo;
      tick();
      set_nop();
   endtask

   // SRAM responder: accepts after addr_lat request cycles, answers data_lat cycles after acceptance.
   task automatic mem_access(input int unsigned addr_lat, input int unsigned data_lat,
                             input logic [31:0] rdata,
                             output int unsigned stall_cnt, output int unsigned accepts,
                             output logic [31:0] req_addr, output logic req_wr,
                             output logic [3:0] req_strb, output logic [31:0] req_wdata,
                             output logic changed, output logic leak, output logic timeout);
      int unsigned req_seen = 0;
      int unsigned acc_at = 0;
      stall_cnt = 0; accepts = 0; changed = 1'b0; leak = 1'b0; timeout = 1'b0;
      req_addr = '0; req_wr = 1'b0; req_strb = '0; req_wdata = '0;
      for (int unsigned c = 1; c <= 60; c++) begin
         if (!stallreq_for_df) break;
         stall_cnt++;
         if (df_rf_we || df_hilo[65] || df_hilo[32]) leak = 1'b1;
         data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
         if (data_req) begin
            if (req_seen == 0) begin
               req_addr = data_addr; req_wr = data_wr; req_strb = data_wstrb; req_wdata = data_wdata;
            end else if ({data_addr, data_wr, data_wstrb, data_wdata} !== {req_addr, req_wr, req_strb, req_wdata}) begin
               changed = 1'b1;
            end
            req_seen++;
            if (req_seen > addr_lat) begin
               data_addr_ok = 1'b1; accepts++; acc_at = c;
            end
         end else if (accepts != 0 && c == acc_at + data_lat) begin
            data_data_ok = 1'b1; data_rdata = rdata;
         end
         tick();
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      timeout = stallreq_for_df;
   endtask

   task automatic test_reset();
      set_nop();
      stall_tb = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
      resetn = 1'b1;
      #1 resetn = 1'b0;
      #1;
      n_vec++; if (data_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b expected 0", data_req); end
      n_vec++; if (stallreq_for_df !== 1'b0) begin n_err++; $display("FAIL reset_stallreq got %b expected 0", stallreq_for_df); end
      n_vec++; if (df_fwd !== '0) begin n_err++; $display("FAIL reset_fwd got %h expected 0", df_fwd); end
      n_vec++; if ({df_pc, df_rf_we, df_rf_waddr, df_hilo} !== '0) begin n_err++;
         $display("FAIL reset_df got pc=%h we=%b wa=%h hilo=%h expected 0", df_pc, df_rf_we, df_rf_waddr, df_hilo); end
      tick(); tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      logic [31:0] e;
      exp_q.push_back(32'h0000_1234);
      issue(32'h0040_0000, 32'h1234, 8'h00, 1'b0, 4'h0, 32'h0, 1'b1, 5'd3, {1'b1, 32'hAAAA0000, 1'b1, 32'h0000BBBB});
      e = exp_q.pop_front();
      n_vec++; if (df_rf_wdata !== e) begin n_err++; $display("FAIL alu_wdata got %h expected %h", df_rf_wdata, e); end
      n_vec++; if ({df_rf_we, df_rf_waddr} !== {1'b1, 5'd3}) begin n_err++; $display("FAIL alu_we got %b/%0d expected 1/3", df_rf_we, df_rf_waddr); end
      n_vec++; if ({data_req, stallreq_for_df} !== 2'b00) begin n_err++; $display("FAIL alu_req got %b%b expected 00", data_req, stallreq_for_df); end
      n_vec++; if (df_hilo !== {1'b1, 32'hAAAA0000, 1'b1, 32'h0000BBBB}) begin n_err++; $display("FAIL alu_hilo got %h", df_hilo); end
      n_vec++; if (df_fwd !== {1'b0, 1'b1, 5'd3, e}) begin n_err++; $display("FAIL alu_fwd got %h expected %h", df_fwd, {1'b0, 1'b1, 5'd3, e}); end
      n_vec++; if (df_pc !== 32'h0040_0000) begin n_err++; $display("FAIL alu_pc got %h expected 00400000", df_pc); end
   endtask

   task automatic test_lw();
      int unsigned sc, acc;
      logic [31:0] ra, rw, e;
      logic wr, chg, lk, to;
      logic [3:0] rs;
      exp_q.push_back(32'hDEADBEEF);
      issue(32'h0040_0010, 32'h100, OP_LW, 1'b1, 4'h0, 32'h0, 1'b1, 5'd8, {1'b1, 32'h11, 1'b1, 32'h22});
      mem_access(1, 2, 32'hDEADBEEF, sc, acc, ra, wr, rs, rw, chg, lk, to);
      e = exp_q.pop_front();
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL lw_timeout got stallreq stuck expected release"); end
      n_vec++; if (sc !== 4) begin n_err++; $display("FAIL lw_stall_cycles got %0d expected 4", sc); end
      n_vec++; if (acc !== 1) begin n_err++; $display("FAIL lw_accepts got %0d expected 1", acc); end
      n_vec++; if ({ra, wr, chg} !== {32'h100, 1'b0, 1'b0}) begin n_err++; $display("FAIL lw_req got addr=%h wr=%b chg=%b expected 100/0/0", ra, wr, chg); end
      n_vec++; if (lk !== 1'b0) begin n_err++; $display("FAIL lw_we_leak got %b expected 0", lk); end
      n_vec++; if (df_rf_wdata !== e) begin n_err++; $display("FAIL lw_wdata got %h expected %h", df_rf_wdata, e); end
      n_vec++; if (df_fwd !== {1'b1, 1'b1, 5'd8, e}) begin n_err++; $display("FAIL lw_fwd got %h expected %h", df_fwd, {1'b1, 1'b1, 5'd8, e}); end
      n_vec++; if (df_hilo !== {1'b1, 32'h11, 1'b1, 32'h22}) begin n_err++; $display("FAIL lw_hilo got %h", df_hilo); end
   endtask

   task automatic test_extend();
      logic [7:0]  ops[6];
      logic [31:0] adr[6];
      logic [31:0] res[6];
      int unsigned sc, acc;
      logic [31:0] ra, rw, e;
      logic wr, chg, lk, to;
      logic [3:0] rs;
      ops = '{OP_LB, OP_LBU, OP_LHU, OP_LH, OP_LB, OP_LH};
      adr = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h102};
      res = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'h00007F01, 32'h0000007F, 32'hFFFF80FF};
      for (int unsigned i = 0; i < 6; i++) begin
         exp_q.push_back(res[i]);
         issue(32'h0040_0100 + 4 * i, adr[i], ops[i], 1'b1, 4'h0, 32'h0, 1'b1, 5'(i + 1), '0);
         mem_access(i % 2, 1 + i % 2, 32'h80FF7F01, sc, acc, ra, wr, rs, rw, chg, lk, to);
         e = exp_q.pop_front();
         n_vec++; if (to !== 1'b0 || sc !== (i % 2) + 1 + (1 + i % 2)) begin n_err++;
            $display("FAIL ext%0d_stall got %0d expected %0d", i, sc, (i % 2) + 2 + i % 2); end
         n_vec++; if (ra !== {adr[i][31:2], 2'b00}) begin n_err++; $display("FAIL ext%0d_addr got %h", i, ra); end
         n_vec++; if (df_rf_wdata !== e) begin n_err++; $display("FAIL ext%0d_wdata got %h expected %h", i, df_rf_wdata, e); end
      end
   endtask

   task automatic test_store();
      int unsigned sc, acc;
      logic [31:0] ra, rw;
      logic wr, chg, lk, to;
      logic [3:0] rs;
      issue(32'h0040_0200, 32'h200, OP_SW, 1'b1, 4'hF, 32'hA5A5A5A5, 1'b0, 5'd0, '0);
      mem_access(3, 1, 32'h0, sc, acc, ra, wr, rs, rw, chg, lk, to);
      n_vec++; if (to !== 1'b0 || sc !== 5) begin n_err++; $display("FAIL sw_stall got %0d expected 5", sc); end
      n_vec++; if (acc !== 1) begin n_err++; $display("FAIL sw_accepts got %0d expected 1", acc); end
      n_vec++; if ({ra, wr, rs, rw} !== {32'h200, 1'b1, 4'hF, 32'hA5A5A5A5}) begin n_err++;
         $display("FAIL sw_req got %h/%b/%h/%h expected 200/1/f/a5a5a5a5", ra, wr, rs, rw); end
      n_vec++; if (chg !== 1'b0) begin n_err++; $display("FAIL sw_hold got changed=%b expected 0", chg); end
      n_vec++; if ({df_rf_we, data_req} !== 2'b00) begin n_err++; $display("FAIL sw_done got we=%b req=%b expected 0/0", df_rf_we, data_req); end
   endtask

   task automatic test_hold();
      int unsigned sc, acc;
      logic [31:0] ra, rw, e;
      logic wr, chg, lk, to;
      logic [3:0] rs;
      exp_q.push_back(32'h12345678);
      issue(32'h0040_0300, 32'h300, OP_LW, 1'b1, 4'h0, 32'h0, 1'b1, 5'd9, '0);
      stall_tb = 6'h3F;
      mem_access(0, 1, 32'h12345678, sc, acc, ra, wr, rs, rw, chg, lk, to);
      e = exp_q.pop_front();
      n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL hold_timeout got stallreq stuck expected release"); end
      for (int unsigned k = 0; k < 5; k++) begin
         n_vec++; if ({data_req, df_rf_wdata, df_rf_we} !== {1'b0, e, 1'b1}) begin n_err++;
            $display("FAIL hold%0d got req=%b wdata=%h we=%b expected 0/%h/1", k, data_req, df_rf_wdata, df_rf_we, e); end
         data_data_ok = 1'b1; data_rdata = 32'h0BAD0BAD;
         tick();
      end
      data_data_ok = 1'b0;
      stall_tb = '0;
      exp_q.push_back(32'h55);
      issue(32'h0040_0304, 32'h55, 8'h00, 1'b0, 4'h0, 32'h0, 1'b1, 5'd4, '0);
      e = exp_q.pop_front();
      n_vec++; if ({df_rf_wdata, df_rf_waddr, stallreq_for_df} !== {e, 5'd4, 1'b0}) begin n_err++;
         $display("FAIL hold_next got %h/%0d/%b expected %h/4/0", df_rf_wdata, df_rf_waddr, stallreq_for_df, e); end
   endtask

   task automatic test_reset_mid();
      int unsigned sc, acc;
      logic [31:0] ra, rw, e;
      logic wr, chg, lk, to;
      logic [3:0] rs;
      issue(32'h0040_0400, 32'h400, OP_LW, 1'b1, 4'h0, 32'h0, 1'b1, 5'd7, '0);
      data_addr_ok = data_req;
      tick();
      data_addr_ok = 1'b0;
      n_vec++; if ({stallreq_for_df, data_req} !== 2'b10) begin n_err++; $display("FAIL rst_wait got stallreq=%b req=%b expected 1/0", stallreq_for_df, data_req); end
      #2 resetn = 1'b0;
      #1;
      n_vec++; if ({data_req, stallreq_for_df} !== 2'b00) begin n_err++; $display("FAIL rst_async got req=%b stallreq=%b expected 0/0", data_req, stallreq_for_df); end
      n_vec++; if ({df_pc, df_rf_we, df_rf_wdata, df_fwd} !== '0) begin n_err++; $display("FAIL rst_async_df got pc=%h wdata=%h fwd=%h expected 0", df_pc, df_rf_wdata, df_fwd); end
      tick();
      resetn = 1'b1;
      data_data_ok = 1'b1; data_rdata = 32'hFFFFFFFF;
      tick();
      data_data_ok = 1'b0;
      n_vec++; if ({data_req, stallreq_for_df, df_rf_we, df_rf_wdata} !== '0) begin n_err++;
         $display("FAIL rst_stray got req=%b stallreq=%b we=%b wdata=%h expected 0", data_req, stallreq_for_df, df_rf_we, df_rf_wdata); end
      exp_q.push_back(32'hCAFEF00D);
      issue(32'h0040_0408, 32'h404, OP_LW, 1'b1, 4'h0, 32'h0, 1'b1, 5'd7, '0);
      mem_access(1, 1, 32'hCAFEF00D, sc, acc, ra, wr, rs, rw, chg, lk, to);
      e = exp_q.pop_front();
      n_vec++; if (to !== 1'b0 || sc !== 3 || acc !== 1) begin n_err++; $display("FAIL rst_next_hs got stall=%0d acc=%0d expected 3/1", sc, acc); end
      n_vec++; if ({ra, df_rf_wdata} !== {32'h404, e}) begin n_err++; $display("FAIL rst_next got addr=%h wdata=%h expected 404/%h", ra, df_rf_wdata, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_lw();
      test_extend();
      test_store();
      test_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
